// File: rtl/sw_stepper.sv
// Debounced switch/button front end that issues single step pulses.
// Define SW_STEPPER_AUTORUN_EN to add a periodic auto-run stepper.
module sw_stepper #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  input  logic       step_btn,
  input  logic       run_en,
  output logic [1:0] sw_in,
  output logic       ctrl_in,
  output logic [7:0] step_count
);

  localparam logic [7:0] SW_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] BTN_LAST = 8'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_REL
  } state_t;

  logic [1:0] sw_s1;
  logic [1:0] sw_sync;
  logic       btn_s1;
  logic       btn_sync;
  logic [1:0] sw_cand;
  logic [7:0] sw_cnt;
  state_t     state;
  state_t     state_nxt;
  logic [7:0] btn_cnt;
  logic [7:0] btn_cnt_nxt;
  logic       man_pulse;
  logic       pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1    <= '0;
      sw_sync  <= '0;
      btn_s1   <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sw_s1    <= sw_raw;
      sw_sync  <= sw_s1;
      btn_s1   <= step_btn;
      btn_sync <= btn_s1;
    end
  end

  // sw_in reloads every stable cycle, so a blocked load lands next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_cand <= '0;
      sw_cnt  <= '0;
      sw_in   <= '0;
    end else if (sw_sync != sw_cand) begin
      sw_cand <= sw_sync;
      sw_cnt  <= '0;
    end else if (sw_cnt != SW_LAST) begin
      sw_cnt  <= sw_cnt + 8'd1;
    end else if (!pulse) begin
      sw_in   <= sw_cand;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      btn_cnt <= '0;
    end else begin
      state   <= state_nxt;
      btn_cnt <= btn_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    btn_cnt_nxt = btn_cnt;
    man_pulse   = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_sync) begin
          state_nxt   = DEB_PRESS;
          btn_cnt_nxt = '0;
        end
      end
      DEB_PRESS: begin
        if (!btn_sync) begin
          state_nxt   = IDLE;
          btn_cnt_nxt = '0;
        end else if (btn_cnt == BTN_LAST) begin
          state_nxt   = HELD;
          btn_cnt_nxt = '0;
          man_pulse   = 1'b1;
        end else begin
          btn_cnt_nxt = btn_cnt + 8'd1;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_nxt   = DEB_REL;
          btn_cnt_nxt = '0;
        end
      end
      DEB_REL: begin
        if (btn_sync) begin
          state_nxt   = HELD;
          btn_cnt_nxt = '0;
        end else if (btn_cnt == BTN_LAST) begin
          state_nxt   = IDLE;
          btn_cnt_nxt = '0;
        end else begin
          btn_cnt_nxt = btn_cnt + 8'd1;
        end
      end
    endcase
  end

`ifdef SW_STEPPER_AUTORUN_EN
  localparam logic [7:0] P_LAST = 8'(AUTO_PERIOD - 1);

  logic       run_s1;
  logic       run_sync;
  logic [7:0] per_cnt;
  logic       auto_pulse;
  logic       auto_live;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_s1   <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_s1   <= run_en;
      run_sync <= run_s1;
    end
  end

  // no auto pulse while a press is starting, so a fast manual pulse
  // can never land on the very next cycle
  assign auto_live  = run_sync && (state == IDLE) && !btn_sync;
  assign auto_pulse = auto_live && (per_cnt == P_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      per_cnt <= '0;
    end else if (!run_sync || state != IDLE || man_pulse) begin
      per_cnt <= '0;
    end else if (per_cnt == P_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 8'd1;
    end
  end

  assign pulse = man_pulse | auto_pulse;
`else
  logic unused_run;
  assign unused_run = run_en;
  assign pulse      = man_pulse;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_in    <= 1'b0;
      step_count <= '0;
    end else begin
      ctrl_in <= pulse;
      if (pulse) step_count <= step_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_sw_stepper.sv
// Self-checking bench for sw_stepper: vector table plus pulse scoreboard.
// Auto-run expectations follow SW_STEPPER_AUTORUN_EN.
module tb_sw_stepper;

  localparam int D = 4;
  localparam int P = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sw_raw = 2'b00;
  logic       step_btn = 1'b0;
  logic       run_en = 1'b0;
  logic [1:0] sw_in;
  logic       ctrl_in;
  logic [7:0] step_count;

  sw_stepper #(
    .DEBOUNCE_CYCLES(D),
    .AUTO_PERIOD(P)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .step_btn(step_btn),
    .run_en(run_en),
    .sw_in(sw_in),
    .ctrl_in(ctrl_in),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    int hold;
    int gap;
    bit pulse;
  } vec_t;

  exp_t       sbq[$];
  logic [7:0] exp_count = 8'd0;
  int         passed = 0;
  int         total = 0;
  logic       prev_ctrl = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push_pulse(input int at);
    exp_t e;
    exp_count = exp_count + 8'd1;
    e.at  = at;
    e.cnt = exp_count;
    sbq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold, input int gap, input bit pls);
    int k;
    k = cyc;
    step_btn = 1'b1;
    if (pls) push_pulse(k + 2 + D);
    tick(hold);
    step_btn = 1'b0;
    tick(gap);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_ctrl = 1'b0;
    end else begin
      while (sbq.size() > 0 && sbq[0].at < cyc) begin
        e = sbq.pop_front();
        chk("missed_pulse_cycle", cyc, e.at);
      end
      if (ctrl_in) begin
        chk("ctrl_consecutive", prev_ctrl, 0);
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", ctrl_in, 0);
        end else begin
          e = sbq.pop_front();
          chk("pulse_cycle", cyc, e.at);
          chk("pulse_count", step_count, e.cnt);
        end
      end
      prev_ctrl = ctrl_in;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[7];
    int   k;
    vt = '{
      '{20, 8, 1'b1},
      '{3,  8, 1'b0},
      '{4,  8, 1'b1},
      '{1,  8, 1'b0},
      '{5,  8, 1'b1},
      '{2,  8, 1'b0},
      '{9, 10, 1'b1}
    };

    #12;
    chk("rst_sw_in", sw_in, 0);
    chk("rst_ctrl_in", ctrl_in, 0);
    chk("rst_step_count", step_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(3);

    for (int i = 0; i < 7; i++) press(vt[i].hold, vt[i].gap, vt[i].pulse);
    tick(2);
    chk("table_count", step_count, exp_count);
    chk("table_drained", sbq.size(), 0);

    k = cyc;
    step_btn = 1'b1;
    push_pulse(k + 2 + D);
    tick(6);
    step_btn = 1'b0;
    tick(2);
    step_btn = 1'b1;
    tick(3);
    step_btn = 1'b0;
    tick(10);
    chk("rel_glitch_count", step_count, exp_count);

    sw_raw = 2'b10;
    tick(6);
    @(negedge clk);
    chk("sw_edge6_old", sw_in, 2'b00);
    @(negedge clk);
    chk("sw_edge7_new", sw_in, 2'b10);
    @(posedge clk);
    #1;
    sw_raw = 2'b11;
    tick(2);
    sw_raw = 2'b10;
    tick(12);
    chk("sw_glitch_kept", sw_in, 2'b10);

    sw_raw = 2'b01;
    tick(1);
    k = cyc;
    step_btn = 1'b1;
    push_pulse(k + 2 + D);
    tick(6);
    chk("sw_defer_hold", sw_in, 2'b10);
    @(posedge clk);
    #1;
    chk("sw_defer_load", sw_in, 2'b01);
    step_btn = 1'b0;
    tick(10);

    step_btn = 1'b1;
    tick(3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_ctrl", ctrl_in, 0);
    chk("async_rst_count", step_count, 0);
    chk("async_rst_sw", sw_in, 0);
    exp_count = 8'd0;
    sbq.delete();
    step_btn = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(20);
    chk("no_pulse_after_rst", step_count, 0);

    reset = 1'b0;
    step_btn = 1'b1;
    tick(3);
    reset = 1'b1;
    k = cyc;
    push_pulse(k + 2 + D);
    tick(20);
    step_btn = 1'b0;
    tick(10);
    chk("held_thru_rst", step_count, exp_count);

    for (int i = 0; i < 255; i++) press(D, D + 4, 1'b1);
    tick(2);
    chk("wrap_count", step_count, exp_count);
    chk("wrap_zero", step_count, 0);
    chk("wrap_drained", sbq.size(), 0);

    k = cyc;
    run_en = 1'b1;
`ifdef SW_STEPPER_AUTORUN_EN
    for (int i = 1; 2 + P * i <= 42; i++) push_pulse(k + 2 + P * i);
`endif
    tick(40);
    run_en = 1'b0;
    tick(12);
    chk("auto_count", step_count, exp_count);
    chk("auto_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
